// File: rtl/vergister_writeback_pkg.sv
// Shared types for the register-file write side: word, register index and write request.
// Latency: n/a (types only). Backpressure: n/a.
// A write request carries its own valid so ALU, completion and write port share one shape.
package vergister_writeback_pkg;

    localparam int REGISTER_COUNT = 32;
    localparam int XLEN           = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      reg_index_t;

    typedef struct packed {
        logic       valid;
        reg_index_t rd;
        word_t      data;
    } wb_req_t;

endpackage

// File: rtl/vergister_scoreboard.sv
// Busy-register scoreboard and pending-op counter for long-latency destinations.
// Latency: busy/count update at the clock edge; hazard and full are combinational from state.
// Backpressure: full forbids further issues; hazard stalls decode until the owner completes.
module vergister_scoreboard
    import vergister_writeback_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    localparam int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  reg_index_t issue_rd,
    input  logic       done_valid,
    input  logic       done_xfer,
    input  reg_index_t done_rd,
    input  reg_index_t dec_rs1,
    input  reg_index_t dec_rs2,
    input  reg_index_t dec_rd,
    output logic       hazard,
    output logic       full
);

    logic [REGISTER_COUNT-1:0] busy_q;
    logic [REGISTER_COUNT-1:0] busy_n;
    logic [CW-1:0]             count_q;
    logic [CW-1:0]             count_n;

    // Set is applied after clear so a same-cycle issue to the completing rd keeps it busy.
    always_comb begin
        busy_n = busy_q;
        if (done_xfer) begin
            busy_n[done_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_n[issue_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    always_comb begin
        count_n = count_q;
        case ({issue_valid, done_xfer})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_n;
            count_q <= count_n;
        end
    end

    assign full   = (count_q == CW'(MAX_PENDING));
    assign hazard = !reset && (((dec_rs1 != '0) && busy_q[dec_rs1]) ||
                               ((dec_rs2 != '0) && busy_q[dec_rs2]) ||
                               ((dec_rd  != '0) && busy_q[dec_rd]));

    a_issue_when_full : assert property (@(posedge clk) disable iff (reset)
        !(issue_valid && full));
    a_issue_to_busy : assert property (@(posedge clk) disable iff (reset)
        !(issue_valid && busy_q[issue_rd] && !(done_xfer && (done_rd == issue_rd))));
    a_done_when_idle : assert property (@(posedge clk) disable iff (reset)
        !(done_valid && (count_q == '0)));
    a_done_not_busy : assert property (@(posedge clk) disable iff (reset)
        !(done_valid && (done_rd != '0) && !busy_q[done_rd]));

endmodule

// File: rtl/vergister_writeback.sv
// Merges ALU results and long-latency completions onto the single register-file write port.
// Latency: one cycle from ALU valid / completion transfer to the registered write port.
// Backpressure: ALU always wins; done_ready drops while alu_valid is high.
module vergister_writeback
    import vergister_writeback_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  reg_index_t issue_rd,
    input  logic       alu_valid,
    input  reg_index_t alu_rd,
    input  word_t      alu_data,
    input  logic       done_valid,
    output logic       done_ready,
    input  reg_index_t done_rd,
    input  word_t      done_data,
    input  reg_index_t dec_rs1,
    input  reg_index_t dec_rs2,
    input  reg_index_t dec_rd,
    output logic       hazard,
    output logic       full,
    output logic       wr_enable,
    output reg_index_t wr_rd,
    output word_t      wr_data
);

    wb_req_t alu_req;
    wb_req_t done_req;
    wb_req_t wr_q;
    logic    done_xfer;

    assign alu_req    = '{valid: alu_valid,  rd: alu_rd,  data: alu_data};
    assign done_req   = '{valid: done_valid, rd: done_rd, data: done_data};
    assign done_ready = !reset && !alu_req.valid;
    assign done_xfer  = done_req.valid && done_ready;

    // Index and data always latch from the winning source; only the enable is masked for x0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
        end else if (alu_req.valid) begin
            wr_q <= '{valid: (alu_req.rd != '0), rd: alu_req.rd, data: alu_req.data};
        end else if (done_xfer) begin
            wr_q <= '{valid: (done_req.rd != '0), rd: done_req.rd, data: done_req.data};
        end else begin
            wr_q.valid <= 1'b0;
        end
    end

    assign wr_enable = wr_q.valid;
    assign wr_rd     = wr_q.rd;
    assign wr_data   = wr_q.data;

    vergister_scoreboard #(
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .done_valid  (done_req.valid),
        .done_xfer   (done_xfer),
        .done_rd     (done_req.rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .hazard      (hazard),
        .full        (full)
    );

endmodule

// File: tb/tb_vergister_writeback.sv
// Randomized and directed bench for vergister_writeback with a queue-based write scoreboard.
module tb_vergister_writeback;

    localparam int MAX_PENDING = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        done_valid;
    logic        done_ready;
    logic [4:0]  done_rd;
    logic [31:0] done_data;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        hazard, full, wr_enable;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    vergister_writeback #(.MAX_PENDING(MAX_PENDING)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_rd(done_rd), .done_data(done_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .full(full),
        .wr_enable(wr_enable), .wr_rd(wr_rd), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          en;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exq[$];
    logic [4:0]  pend[$];   // destinations of in-flight long-latency ops (multiset)
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    bit          last_xfer = 0;
    logic [4:0]  hold_rd = '0;
    logic [31:0] hold_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic bit mbusy(logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (pend[i]) if (pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Write-port monitor: an expected write for this cycle must appear, otherwise the port idles and holds.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("wr_enable_in_reset", {31'd0, wr_enable}, 32'd0);
            hold_rd   = '0;
            hold_data = '0;
        end else begin
            while (exq.size() > 0 && exq[0].cyc < cyc) begin
                e = exq.pop_front();
                check("wr_missed_cycle", e.cyc, cyc);
            end
            if (exq.size() > 0 && exq[0].cyc == cyc) begin
                e = exq.pop_front();
                check("wr_enable", {31'd0, wr_enable}, {31'd0, e.en});
                check("wr_rd", {27'd0, wr_rd}, {27'd0, e.rd});
                check("wr_data", wr_data, e.data);
                hold_rd   = e.rd;
                hold_data = e.data;
            end else begin
                check("wr_enable_idle", {31'd0, wr_enable}, 32'd0);
                check("wr_rd_hold", {27'd0, wr_rd}, {27'd0, hold_rd});
                check("wr_data_hold", wr_data, hold_data);
            end
        end
    end

    // One clock of stimulus: check combinational outputs against the model, then advance the model.
    task automatic tick();
        bit xfer;
        int idx;
        @(negedge clk);
        check("done_ready", {31'd0, done_ready}, {31'd0, (!reset && !alu_valid)});
        check("hazard", {31'd0, hazard},
              {31'd0, (!reset && (mbusy(dec_rs1) || mbusy(dec_rs2) || mbusy(dec_rd)))});
        check("full", {31'd0, full}, {31'd0, (pend.size() == MAX_PENDING)});
        xfer = done_valid && !alu_valid && !reset;
        if (reset) begin
            pend.delete();
            exq.delete();
        end else begin
            if (alu_valid) exq.push_back('{cyc + 1, alu_rd != 5'd0, alu_rd, alu_data});
            else if (xfer) exq.push_back('{cyc + 1, done_rd != 5'd0, done_rd, done_data});
            if (xfer) begin
                idx = -1;
                foreach (pend[i]) if (idx < 0 && pend[i] == done_rd) idx = i;
                if (idx >= 0) pend.delete(idx);
            end
            if (issue_valid) pend.push_back(issue_rd);
        end
        last_xfer = xfer;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; alu_valid = 0; done_valid = 0;
    endtask

    task automatic issue(logic [4:0] rd);
        idle(); issue_valid = 1; issue_rd = rd; tick(); idle();
    endtask

    task automatic complete(logic [4:0] rd, logic [31:0] d);
        idle(); done_valid = 1; done_rd = rd; done_data = d; tick(); idle();
    endtask

    initial begin
        logic [4:0] r;
        reset = 1; idle();
        issue_rd = 0; alu_rd = 0; alu_data = 0; done_rd = 0; done_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        tick();

        // ALU write
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; tick(); idle(); tick(); tick();

        // Scoreboard hazard on rd 7
        issue(5'd7);
        dec_rs1 = 5'd7; tick(); tick();
        complete(5'd7, 32'h12);
        tick(); dec_rs1 = 0;

        // ALU/completion collision
        issue(5'd3);
        dec_rs1 = 5'd3;
        done_valid = 1; done_rd = 5'd3; done_data = 32'h33;
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44; tick();
        alu_valid = 0; tick();
        idle(); tick(); tick(); dec_rs1 = 0;

        // Full and count
        issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
        tick();
        complete(5'd2, 32'h222);
        tick();
        issue_valid = 1; issue_rd = 5'd5; done_valid = 1; done_rd = 5'd1; done_data = 32'h111;
        tick(); idle(); tick();
        complete(5'd3, 32'h3); complete(5'd4, 32'h4); complete(5'd5, 32'h5);

        // x0 and same-cycle set/clear
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hABCD; tick(); idle(); tick();
        issue(5'd9);
        issue_valid = 1; issue_rd = 5'd9; done_valid = 1; done_rd = 5'd9; done_data = 32'h99;
        tick(); idle();
        dec_rd = 5'd9; tick(); dec_rd = 0;
        complete(5'd9, 32'h999);

        // Reset mid-flight
        issue(5'd10); issue(5'd11); issue(5'd0);
        dec_rs1 = 5'd10; tick();
        reset = 1; tick();
        reset = 0; tick();
        alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h600D; tick(); idle(); tick(); tick();
        dec_rs1 = 0;

        // Randomized traffic with out-of-order completions
        for (int n = 0; n < 1500; n++) begin
            issue_valid = 0;
            if (done_valid && last_xfer) done_valid = 0;
            if (!done_valid && pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                done_valid = 1;
                done_rd    = pend[$urandom_range(0, pend.size() - 1)];
                done_data  = $urandom;
            end
            if (pend.size() < MAX_PENDING && $urandom_range(0, 1) == 0) begin
                r = 5'($urandom_range(0, 31));
                if (!mbusy(r)) begin
                    issue_valid = 1;
                    issue_rd    = r;
                end
            end
            alu_valid = ($urandom_range(0, 3) == 0);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = $urandom;
            dec_rs1   = (pend.size() > 0 && $urandom_range(0, 1) == 0) ?
                        pend[$urandom_range(0, pend.size() - 1)] : 5'($urandom_range(0, 31));
            dec_rs2   = 5'($urandom_range(0, 31));
            dec_rd    = 5'($urandom_range(0, 31));
            tick();
        end

        idle(); tick(); tick(); tick();
        check("write_queue_drained", exq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
